// File: rtl/adc_serial_responder.sv
// Device-side model of the 3-wire serial ADC link: answers a reader's nCS/SClk
// frames with {LeadingZeros zeros, sample} shifted out MSB-first on Data.
module adc_serial_responder #(
  parameter int Width        = 12,
  parameter int LeadingZeros = 4,
  parameter int SyncStages   = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             nCS,
  input  logic             SClk,
  output logic             Data,
  output logic             Data_Enable,
  input  logic [Width-1:0] Sample,
  input  logic             Sample_Valid,
  output logic             Sample_Ready,
  output logic             Frame_Done,
  output logic             Frame_Abort,
  output logic [7:0]       Stale_Count
);

  localparam int N    = LeadingZeros + Width;
  localparam int CntW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  logic [SyncStages-1:0] ncs_sync, sclk_sync, flush;
  logic ncs_prev, sclk_prev, armed;
  logic ncs_s, sclk_s, ncs_fall, ncs_rise, sclk_fall;

  state_t           state_q, state_d;
  logic [N-1:0]     shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             de_q, de_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic [Width-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [Width-1:0] last_q, last_d;
  logic [7:0]       stale_q, stale_d;
  logic [Width-1:0] frame_src;
  logic             accept;

  // Synchronisers plus one edge-detect flop per line; all reset to idle-high.
  always_ff @(posedge Clk) begin
    // NOTE: state elements use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    if (Reset) begin
      ncs_sync  <= '1;
      sclk_sync <= '1;
      ncs_prev  <= 1'b1;
      sclk_prev <= 1'b1;
      flush     <= '0;
      armed     <= 1'b0;
    end else begin
      ncs_sync  <= {ncs_sync[SyncStages-2:0], nCS};
      sclk_sync <= {sclk_sync[SyncStages-2:0], SClk};
      ncs_prev  <= ncs_s;
      sclk_prev <= sclk_s;
      flush     <= {flush[SyncStages-2:0], 1'b1};
      armed     <= armed | (flush[SyncStages-1] & ncs_s);
    end
  end

  assign ncs_s     = ncs_sync[SyncStages-1];
  assign sclk_s    = sclk_sync[SyncStages-1];
  // A frame may only start once a genuine high nCS has been seen after reset,
  // so a reader holding nCS low through reset cannot trigger a false frame.
  assign ncs_fall  = armed & ncs_prev & ~ncs_s;
  assign ncs_rise  = ~ncs_prev & ncs_s;
  assign sclk_fall = sclk_prev & ~sclk_s;

  assign accept    = Sample_Valid & ~pend_full_q;
  assign frame_src = pend_full_q ? pend_q : last_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    de_d        = de_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    last_d      = last_q;
    stale_d     = stale_q;

    if (accept) begin
      pend_d      = Sample;
      pend_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          shift_d              = '0;
          shift_d[Width-1:0]   = frame_src;
          last_d               = frame_src;
          cnt_d                = CntW'(1);
          de_d                 = 1'b1;
          state_d              = SHIFT;
          // A sample accepted in this same cycle becomes the next pending one.
          pend_full_d          = accept;
          if (!pend_full_q && stale_q != 8'hFF) stale_d = stale_q + 8'd1;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          abort_d = 1'b1;
          de_d    = 1'b0;
          state_d = IDLE;
        end else if (sclk_fall) begin
          shift_d = {shift_q[N-2:0], 1'b0};
          if (cnt_q == CntW'(N)) begin
            done_d  = 1'b1;
            state_d = TAIL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TAIL: begin
        if (ncs_rise) begin
          de_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      de_q        <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      last_q      <= '0;
      stale_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      de_q        <= de_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      last_q      <= last_d;
      stale_q     <= stale_d;
    end
  end

  assign Data         = shift_q[N-1];
  assign Data_Enable  = de_q;
  assign Sample_Ready = ~pend_full_q;
  assign Frame_Done   = done_q;
  assign Frame_Abort  = abort_q;
  assign Stale_Count  = stale_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Self-checking bench for adc_serial_responder: a reader model drives frames,
// a monitor captures Data per SClk fall and checks each frame against a queue.
module tb_adc_serial_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        nCS = 1'b1;
  logic        SClk = 1'b1;
  logic        Data, Data_Enable;
  logic [11:0] Sample = '0;
  logic        Sample_Valid = 1'b0;
  logic        Sample_Ready, Frame_Done, Frame_Abort;
  logic [7:0]  Stale_Count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          n_done;
    int          n_abort;
    logic [7:0]  stale;
    logic        ready;
  } frame_exp_t;

  frame_exp_t exp_q[$];

  adc_serial_responder dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .nCS          (nCS),
    .SClk         (SClk),
    .Data         (Data),
    .Data_Enable  (Data_Enable),
    .Sample       (Sample),
    .Sample_Valid (Sample_Valid),
    .Sample_Ready (Sample_Ready),
    .Frame_Done   (Frame_Done),
    .Frame_Abort  (Frame_Abort),
    .Stale_Count  (Stale_Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after a rising Clk edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic expect_frame(input logic [31:0] bits, input int nbits, input int n_done,
                              input int n_abort, input int stale, input logic ready);
    frame_exp_t e;
    e.bits = bits; e.nbits = nbits; e.n_done = n_done; e.n_abort = n_abort;
    e.stale = 8'(stale); e.ready = ready;
    exp_q.push_back(e);
  endtask

  task automatic load_sample(input logic [11:0] v);
    Sample = v;
    Sample_Valid = 1'b1;
    wait_cyc(1);
    Sample_Valid = 1'b0;
    check("ready_after_load", Sample_Ready, 1'b0);
  endtask

  // One reader frame: nCS low, `pulses` SClk low/high pulses (5 Clk each), nCS high.
  // With `simul` set, Sample_Valid is driven in the cycle the synced nCS fall is seen.
  task automatic run_frame(input int pulses, input bit simul = 1'b0, input logic [11:0] v = '0);
    nCS = 1'b0;
    wait_cyc(2);
    check("de_before_start", Data_Enable, 1'b0);
    if (simul) begin
      Sample = v;
      Sample_Valid = 1'b1;
    end
    wait_cyc(1);
    Sample_Valid = 1'b0;
    check("de_at_start", Data_Enable, 1'b1);
    check("data_first_bit", Data, 1'b0);
    wait_cyc(5);
    for (int i = 0; i < pulses; i++) begin
      SClk = 1'b0;
      wait_cyc(5);
      SClk = 1'b1;
      wait_cyc(5);
    end
    nCS = 1'b1;
    wait_cyc(2);
    check("de_held_after_ncs_rise", Data_Enable, 1'b1);
    wait_cyc(1);
    check("de_off_after_ncs_rise", Data_Enable, 1'b0);
    wait_cyc(7);
  endtask

  // Monitor: capture Data at each SClk fall while enabled, count pulses, and
  // close out the frame when Data_Enable drops.
  initial begin
    logic [31:0] cap = '0;
    int nb = 0, nd = 0, na = 0;
    logic sclk_m = 1'b1, de_m = 1'b0;
    frame_exp_t e;
    forever begin
      @(negedge Clk);
      if (sclk_m && !SClk && Data_Enable) begin
        cap = {cap[30:0], Data};
        nb++;
      end
      if (Frame_Done) nd++;
      if (Frame_Abort) na++;
      if (de_m && !Data_Enable) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(nb), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("frame_bits", cap, e.bits);
          check("frame_nbits", 32'(nb), 32'(e.nbits));
          check("frame_done_pulses", 32'(nd), 32'(e.n_done));
          check("frame_abort_pulses", 32'(na), 32'(e.n_abort));
          check("frame_stale_count", 32'(Stale_Count), 32'(e.stale));
          check("frame_sample_ready", 32'(Sample_Ready), 32'(e.ready));
        end
        cap = '0; nb = 0; nd = 0; na = 0;
      end
      sclk_m = SClk;
      de_m = Data_Enable;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    wait_cyc(4);
    check("reset_de", Data_Enable, 1'b0);
    check("reset_data", Data, 1'b0);
    check("reset_ready", Sample_Ready, 1'b1);
    check("reset_stale", 32'(Stale_Count), 32'd0);
    check("reset_done", Frame_Done, 1'b0);
    Reset = 1'b0;
    wait_cyc(6);

    // Basic frame.
    load_sample(12'hA5C);
    expect_frame(32'h0A5C, 16, 1, 0, 0, 1'b1);
    run_frame(16);

    // Stale frame repeats the last sample.
    expect_frame(32'h0A5C, 16, 1, 0, 1, 1'b1);
    run_frame(16);

    // Abort after 7 falls: first 7 bits of 0x0A5C are 0000101.
    expect_frame(32'h05, 7, 0, 1, 2, 1'b1);
    run_frame(7);
    check("ready_after_abort", Sample_Ready, 1'b1);
    load_sample(12'h123);
    expect_frame(32'h0123, 16, 1, 0, 2, 1'b1);
    run_frame(16);

    // Overrun clocks: 20 falls, bits 17-20 are zero, one Frame_Done.
    load_sample(12'h3C7);
    expect_frame(32'h03C70, 20, 1, 0, 2, 1'b1);
    run_frame(20);

    // Simultaneous load: frame carries the previous sample, 0xFFF goes next.
    expect_frame(32'h03C7, 16, 1, 0, 3, 1'b0);
    run_frame(16, 1'b1, 12'hFFF);
    expect_frame(32'h0FFF, 16, 1, 0, 3, 1'b1);
    run_frame(16);

    // 300 short stale frames (nCS low/high, no clocks) saturate Stale_Count.
    for (int k = 1; k <= 300; k++) begin
      expect_frame(32'h0, 0, 0, 1, (3 + k > 255) ? 255 : 3 + k, 1'b1);
      run_frame(0);
    end
    check("stale_saturated", 32'(Stale_Count), 32'd255);

    // Reset after 5 bits of a frame, with nCS still held low afterwards.
    load_sample(12'h5A5);
    expect_frame(32'h0, 5, 0, 0, 0, 1'b1);
    nCS = 1'b0;
    wait_cyc(8);
    for (int i = 0; i < 5; i++) begin
      SClk = 1'b0;
      wait_cyc(5);
      SClk = 1'b1;
      wait_cyc(5);
    end
    Reset = 1'b1;
    wait_cyc(1);
    check("midreset_de", Data_Enable, 1'b0);
    check("midreset_ready", Sample_Ready, 1'b1);
    check("midreset_stale", 32'(Stale_Count), 32'd0);
    check("midreset_data", Data, 1'b0);
    Reset = 1'b0;
    wait_cyc(20);
    check("no_spurious_start", Data_Enable, 1'b0);
    nCS = 1'b1;
    wait_cyc(10);
    // Pending and last sample were cleared, so a stale all-zero frame follows.
    expect_frame(32'h0, 16, 1, 0, 1, 1'b1);
    run_frame(16);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) wait_cyc(1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
